// File: rtl/pma_check_pipe.sv
// Core-configuration package and a two-stage pipelined PMA lookup.
// Each request address is matched against the non-idempotent, execute and
// cacheable region tables. The response returns the attribute bits and a
// fetch-execute fault flag.

package config_pkg;

   localparam int unsigned NrMaxRules = 16;

   // Region tables. Only the first Nr*Rules entries of each table are live.
   typedef struct packed {
      int unsigned                 NrNonIdempotentRules;
      logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
      logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
      int unsigned                 NrExecuteRegionRules;
      logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
      logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
      int unsigned                 NrCachedRegionRules;
      logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
      logic [NrMaxRules-1:0][63:0] CachedRegionLength;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

   // A configuration is usable when no table claims more rules than exist.
   function automatic bit check_cfg(input cva6_cfg_t cfg);
      return (cfg.NrNonIdempotentRules <= NrMaxRules) &&
             (cfg.NrExecuteRegionRules <= NrMaxRules) &&
             (cfg.NrCachedRegionRules  <= NrMaxRules);
   endfunction

endpackage

module pma_check_pipe
   import config_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
   parameter int unsigned TagWidth = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [63:0]         req_addr_i,
   input  logic [TagWidth-1:0] req_tag_i,
   input  logic                req_fetch_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [63:0]         rsp_addr_o,
   output logic [TagWidth-1:0] rsp_tag_o,
   output logic                rsp_cacheable_o,
   output logic                rsp_nonidem_o,
   output logic                rsp_exec_o,
   output logic                rsp_fault_o
);

   // With no execute rules configured, every address is executable.
   localparam bit ExecAll = (CVA6Cfg.NrExecuteRegionRules == 0);

`ifndef SYNTHESIS
   initial begin : p_cfg_check
      assert (check_cfg(CVA6Cfg))
         else $fatal(1, "pma_check_pipe: a rule count exceeds the table size");
   end
`endif

   // The region end is formed in 65 bits, so a region that ends exactly
   // at 2^64 does not wrap to zero.
   function automatic logic range_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] len);
      logic [64:0] region_end;
      region_end = {1'b0, base} + {1'b0, len};
      return (addr >= base) && ({1'b0, addr} < region_end);
   endfunction

   logic [NrMaxRules-1:0] w_nonidem_hits;
   logic [NrMaxRules-1:0] w_exec_hits;
   logic [NrMaxRules-1:0] w_cached_hits;

   // Rule slots at or above the configured count are tied to 0, so stale
   // table contents can never match.
   for (genvar k = 0; k < NrMaxRules; k++) begin : g_rule
      if (k < int'(CVA6Cfg.NrNonIdempotentRules)) begin : g_nonidem
         assign w_nonidem_hits[k] = range_hit(req_addr_i,
            CVA6Cfg.NonIdempotentAddrBase[k], CVA6Cfg.NonIdempotentLength[k]);
      end else begin : g_nonidem_off
         assign w_nonidem_hits[k] = 1'b0;
      end
      if (k < int'(CVA6Cfg.NrExecuteRegionRules)) begin : g_exec
         assign w_exec_hits[k] = range_hit(req_addr_i,
            CVA6Cfg.ExecuteRegionAddrBase[k], CVA6Cfg.ExecuteRegionLength[k]);
      end else begin : g_exec_off
         assign w_exec_hits[k] = 1'b0;
      end
      if (k < int'(CVA6Cfg.NrCachedRegionRules)) begin : g_cached
         assign w_cached_hits[k] = range_hit(req_addr_i,
            CVA6Cfg.CachedRegionAddrBase[k], CVA6Cfg.CachedRegionLength[k]);
      end else begin : g_cached_off
         assign w_cached_hits[k] = 1'b0;
      end
   end

   // Stage 1 holds the request and the raw per-rule hit vectors.
   logic                  r_s1_valid;
   logic [63:0]           r_s1_addr;
   logic [TagWidth-1:0]   r_s1_tag;
   logic                  r_s1_fetch;
   logic [NrMaxRules-1:0] r_s1_nonidem_hits;
   logic [NrMaxRules-1:0] r_s1_exec_hits;
   logic [NrMaxRules-1:0] r_s1_cached_hits;

   // Stage 2 holds the reduced attributes and drives the response port.
   logic                  r_s2_valid;
   logic [63:0]           r_s2_addr;
   logic [TagWidth-1:0]   r_s2_tag;
   logic                  r_s2_cacheable;
   logic                  r_s2_nonidem;
   logic                  r_s2_exec;
   logic                  r_s2_fault;

   logic w_s2_ready;
   logic w_s1_ready;
   logic w_accept;
   logic w_advance;
   logic w_release;
   logic w_s1_exec;
   logic w_s1_valid_nxt;
   logic w_s2_valid_nxt;

   // Elastic handshake: a stage can take new data when it is empty or when
   // it is being drained in the same cycle. Flush blocks accept and advance.
   assign w_s2_ready  = ~r_s2_valid | rsp_ready_i;
   assign w_s1_ready  = ~r_s1_valid | w_s2_ready;
   assign req_ready_o = w_s1_ready & ~flush_i;
   assign w_accept    = req_valid_i & req_ready_o;
   assign w_advance   = r_s1_valid & w_s2_ready & ~flush_i;
   assign w_release   = r_s2_valid & rsp_ready_i;
   assign w_s1_exec   = ExecAll ? 1'b1 : |r_s1_exec_hits;

   // Next-state of the two valid bits. Flush wins over everything.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the
      // block leaves it unassigned and no latch is inferred.
      w_s1_valid_nxt = r_s1_valid;
      w_s2_valid_nxt = r_s2_valid;
      if (flush_i) begin
         w_s1_valid_nxt = 1'b0;
         w_s2_valid_nxt = 1'b0;
      end else begin
         if (w_accept) begin
            w_s1_valid_nxt = 1'b1;
         end else if (w_advance) begin
            w_s1_valid_nxt = 1'b0;
         end
         if (w_advance) begin
            w_s2_valid_nxt = 1'b1;
         end else if (w_release) begin
            w_s2_valid_nxt = 1'b0;
         end
      end
   end

   // Valid bits of both stages.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: state uses non-blocking assignments, so every flop samples
      // pre-edge values regardless of the order in which blocks evaluate.
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_s1_valid_nxt;
         r_s2_valid <= w_s2_valid_nxt;
      end
   end

   // Stage 1 payload captures on accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: payload registers are reset as well, not only the valid bits,
      // so the response data port reads all-zero straight out of reset.
      if (!rst_ni) begin
         r_s1_addr         <= '0;
         r_s1_tag          <= '0;
         r_s1_fetch        <= 1'b0;
         r_s1_nonidem_hits <= '0;
         r_s1_exec_hits    <= '0;
         r_s1_cached_hits  <= '0;
      end else if (w_accept) begin
         r_s1_addr         <= req_addr_i;
         r_s1_tag          <= req_tag_i;
         r_s1_fetch        <= req_fetch_i;
         r_s1_nonidem_hits <= w_nonidem_hits;
         r_s1_exec_hits    <= w_exec_hits;
         r_s1_cached_hits  <= w_cached_hits;
      end
   end

   // Stage 2 payload: reduces the hit vectors and captures on advance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s2_addr      <= '0;
         r_s2_tag       <= '0;
         r_s2_cacheable <= 1'b0;
         r_s2_nonidem   <= 1'b0;
         r_s2_exec      <= 1'b0;
         r_s2_fault     <= 1'b0;
      end else if (w_advance) begin
         r_s2_addr      <= r_s1_addr;
         r_s2_tag       <= r_s1_tag;
         r_s2_cacheable <= |r_s1_cached_hits;
         r_s2_nonidem   <= |r_s1_nonidem_hits;
         r_s2_exec      <= w_s1_exec;
         r_s2_fault     <= r_s1_fetch & ~w_s1_exec;
      end
   end

   assign rsp_valid_o     = r_s2_valid;
   assign rsp_addr_o      = r_s2_addr;
   assign rsp_tag_o       = r_s2_tag;
   assign rsp_cacheable_o = r_s2_cacheable;
   assign rsp_nonidem_o   = r_s2_nonidem;
   assign rsp_exec_o      = r_s2_exec;
   assign rsp_fault_o     = r_s2_fault;

endmodule

// File: tb/tb_pma_check_pipe.sv
// Self-checking bench for pma_check_pipe. A main instance uses the reference
// region map. A second instance has the same map with its execute-rule count
// set to 0.
module tb_pma_check_pipe;
   import config_pkg::*;

   typedef struct {
      logic [63:0] addr;
      logic [3:0]  tag;
      logic        c;
      logic        n;
      logic        e;
      logic        f;
   } exp_t;

   // Reference map. Cached slot 2 is populated but sits beyond the cached
   // rule count, so it must never match.
   function automatic cva6_cfg_t make_cfg(input bit no_exec);
      cva6_cfg_t c;
      c = '0;
      c.NrNonIdempotentRules     = 1;
      c.NonIdempotentAddrBase[0] = 64'h0;
      c.NonIdempotentLength[0]   = 64'h8000_0000;
      c.NrExecuteRegionRules     = no_exec ? 0 : 2;
      c.ExecuteRegionAddrBase[0] = 64'h1_0000;
      c.ExecuteRegionLength[0]   = 64'h1_0000;
      c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
      c.ExecuteRegionLength[1]   = 64'h4000_0000;
      c.NrCachedRegionRules      = 2;
      c.CachedRegionAddrBase[0]  = 64'h8000_0000;
      c.CachedRegionLength[0]    = 64'h4000_0000;
      c.CachedRegionAddrBase[1]  = 64'hFFFF_FFFF_FFFF_F000;
      c.CachedRegionLength[1]    = 64'h1000;
      c.CachedRegionAddrBase[2]  = 64'h0;
      c.CachedRegionLength[2]    = 64'h1_0000_0000;
      return c;
   endfunction

   localparam cva6_cfg_t CFG_MAIN = make_cfg(1'b0);
   localparam cva6_cfg_t CFG_NX   = make_cfg(1'b1);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic [63:0] req_addr = '0;
   logic [3:0]  req_tag = '0;
   logic        req_fetch = 1'b0;
   logic        rsp_ready = 1'b0;

   logic        req_ready, rsp_valid, rsp_c, rsp_n, rsp_e, rsp_f;
   logic [63:0] rsp_addr;
   logic [3:0]  rsp_tag;
   logic        nx_req_ready, nx_rsp_valid, nx_c, nx_n, nx_e, nx_f;
   logic [63:0] nx_addr;
   logic [3:0]  nx_tag;

   int   n_vec = 0;
   int   n_miss = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   pma_check_pipe #(.CVA6Cfg(CFG_MAIN), .TagWidth(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_tag_i(req_tag), .req_fetch_i(req_fetch),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_addr_o(rsp_addr), .rsp_tag_o(rsp_tag),
      .rsp_cacheable_o(rsp_c), .rsp_nonidem_o(rsp_n),
      .rsp_exec_o(rsp_e), .rsp_fault_o(rsp_f));

   pma_check_pipe #(.CVA6Cfg(CFG_NX), .TagWidth(4)) u_dut_nx (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(nx_req_ready),
      .req_addr_i(req_addr), .req_tag_i(req_tag), .req_fetch_i(req_fetch),
      .rsp_valid_o(nx_rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_addr_o(nx_addr), .rsp_tag_o(nx_tag),
      .rsp_cacheable_o(nx_c), .rsp_nonidem_o(nx_n),
      .rsp_exec_o(nx_e), .rsp_fault_o(nx_f));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Region membership using plain 65-bit arithmetic over the live slots.
   function automatic logic in_region(input int unsigned n,
                                      input logic [15:0][63:0] base,
                                      input logic [15:0][63:0] len,
                                      input logic [63:0] a);
      logic        hit;
      logic [64:0] lo, hi, x;
      hit = 1'b0;
      x = 65'(a);
      for (int k = 0; k < 16; k++) begin
         lo = 65'(base[k]);
         hi = lo + 65'(len[k]);
         if (k < int'(n) && x >= lo && x < hi) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic exp_t model(input logic [63:0] a, input logic [3:0] t, input logic fetch);
      exp_t r;
      r.addr = a;
      r.tag  = t;
      r.c = in_region(CFG_MAIN.NrCachedRegionRules, CFG_MAIN.CachedRegionAddrBase,
                      CFG_MAIN.CachedRegionLength, a);
      r.n = in_region(CFG_MAIN.NrNonIdempotentRules, CFG_MAIN.NonIdempotentAddrBase,
                      CFG_MAIN.NonIdempotentLength, a);
      r.e = (CFG_MAIN.NrExecuteRegionRules == 0) ? 1'b1 :
            in_region(CFG_MAIN.NrExecuteRegionRules, CFG_MAIN.ExecuteRegionAddrBase,
                      CFG_MAIN.ExecuteRegionLength, a);
      r.f = fetch & ~r.e;
      return r;
   endfunction

   // Addresses clustered around region edges, with fully random ones mixed in.
   function automatic logic [63:0] rand_addr();
      logic [63:0] b;
      case ($urandom_range(0, 7))
         0: b = 64'h0;
         1: b = 64'h8000_0000;
         2: b = 64'hC000_0000;
         3: b = 64'h1_0000;
         4: b = 64'h2_0000;
         5: b = 64'hFFFF_FFFF_FFFF_F000;
         6: b = 64'h0;
         default: return {$urandom, $urandom};
      endcase
      return b + 64'($urandom_range(0, 4)) - 64'd2;
   endfunction

   // Scoreboard: at each falling edge, predict the handshakes that the
   // next rising edge will complete, and check the visible response against
   // the oldest outstanding entry.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            chk("rsp_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               chk("rsp_addr", rsp_addr, q[0].addr);
               chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
               chk("rsp_cacheable", 64'(rsp_c), 64'(q[0].c));
               chk("rsp_nonidem", 64'(rsp_n), 64'(q[0].n));
               chk("rsp_exec", 64'(rsp_e), 64'(q[0].e));
               chk("rsp_fault", 64'(rsp_f), 64'(q[0].f));
               chk("nx_tag", 64'(nx_tag), 64'(q[0].tag));
               chk("nx_cacheable", 64'(nx_c), 64'(q[0].c));
               chk("nx_exec", 64'(nx_e), 64'd1);
               chk("nx_fault", 64'(nx_f), 64'd0);
            end
         end
         if (rsp_valid && rsp_ready && q.size() != 0) void'(q.pop_front());
         if (flush) q.delete();
         else if (req_valid && req_ready) q.push_back(model(req_addr, req_tag, req_fetch));
      end
   end

   always @(negedge rst_n) q.delete();

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   // Single lookup into an empty pipe with rsp_ready high. The expected
   // attribute bits are given directly.
   task automatic lookup(input string nm, input logic [63:0] a, input logic [3:0] t,
                         input logic fetch, input logic c, input logic n,
                         input logic e, input logic f);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = a; req_tag = t; req_fetch = fetch;
      @(negedge clk);
      chk({nm, "_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_lat1"}, 64'(rsp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_tag"}, 64'(rsp_tag), 64'(t));
      chk({nm, "_addr"}, rsp_addr, a);
      chk({nm, "_c"}, 64'(rsp_c), 64'(c));
      chk({nm, "_n"}, 64'(rsp_n), 64'(n));
      chk({nm, "_e"}, 64'(rsp_e), 64'(e));
      chk({nm, "_f"}, 64'(rsp_f), 64'(f));
      chk({nm, "_nx_e"}, 64'(nx_e), 64'd1);
      chk({nm, "_nx_f"}, 64'(nx_f), 64'd0);
   endtask

   initial begin
      static logic exp_rdy[7]  = '{1, 1, 0, 0, 1, 1, 1};
      static logic exp_val[10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
      static int   exp_tag[10] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 0};
      int sent;
      int waited;

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_addr", rsp_addr, 64'd0);
      chk("rst_tag", 64'(rsp_tag), 64'd0);
      chk("rst_attr", 64'({rsp_c, rsp_n, rsp_e, rsp_f}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rel_ready", 64'(req_ready), 64'd1);

      // Basic lookups and region boundaries
      lookup("basic_fetch", 64'h8000_0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      lookup("basic_load",  64'h1000_0000, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      lookup("bnd_cache_top", 64'hBFFF_FFFF, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      lookup("bnd_cache_end", 64'hC000_0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      lookup("bnd_nonidem",   64'h7FFF_FFFF, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      lookup("bnd_exec_end",  64'h2_0000, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      lookup("bnd_exec_top",  64'h1_FFFF, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      lookup("wrap_top",  64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      lookup("wrap_below", 64'hFFFF_FFFF_FFFF_EFFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lookup("wrap_fetch", 64'hFFFF_FFFF_FFFF_F000, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      // Backpressure: five back-to-back requests, rsp_ready low for 4 cycles
      sent = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         rsp_ready = (c >= 4);
         req_valid = (sent < 5);
         req_tag   = 4'(sent);
         req_addr  = rand_addr();
         req_fetch = 1'($urandom);
         @(negedge clk);
         if (c < 7) chk($sformatf("bp_ready_c%0d", c), 64'(req_ready), 64'(exp_rdy[c]));
         chk($sformatf("bp_valid_c%0d", c), 64'(rsp_valid), 64'(exp_val[c]));
         if (exp_val[c]) chk($sformatf("bp_tag_c%0d", c), 64'(rsp_tag), 64'(exp_tag[c]));
         if (req_valid && req_ready) sent++;
      end
      chk("bp_sent", 64'(sent), 64'd5);

      // Flush with two entries in flight and a request pending
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_tag = 4'hA; req_addr = 64'h8000_0100; req_fetch = 1'b0;
      @(posedge clk); #1;
      req_tag = 4'hB;
      @(posedge clk); #1;
      req_tag = 4'hC; flush = 1'b1;
      @(negedge clk);
      chk("fl_ready", 64'(req_ready), 64'd0);
      chk("fl_valid_in_cycle", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("fl_gone1", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("fl_gone2", 64'(rsp_valid), 64'd0);
      lookup("fl_fresh", 64'h1_8000, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset with two stalled entries
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_tag = 4'd1; req_addr = 64'h9000_0000; req_fetch = 1'b1;
      @(posedge clk); #1;
      req_tag = 4'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("ar_pre_valid", 64'(rsp_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(rsp_valid), 64'd0);
      chk("ar_nx_valid", 64'(nx_rsp_valid), 64'd0);
      chk("ar_addr", rsp_addr, 64'd0);
      chk("ar_tag", 64'(rsp_tag), 64'd0);
      chk("ar_attr", 64'({rsp_c, rsp_n, rsp_e, rsp_f}), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_rel_ready", 64'(req_ready), 64'd1);
      chk("ar_rel_valid", 64'(rsp_valid), 64'd0);
      lookup("ar_fresh", 64'hC000_0000, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic with occasional flushes, checked by the scoreboard
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         req_valid = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         req_addr  = rand_addr();
         req_tag   = 4'($urandom);
         req_fetch = 1'($urandom);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
      waited = 0;
      while (q.size() != 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'd0);
      chk("drain_valid", 64'(rsp_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pma_check_pipe.md
Name: pma_check_pipe

Overview:
- Pipelined physical-memory-attribute (PMA) lookup stage. It sits between address generation (fetch or LSU) and the cache/bus request path.
- For each physical address it evaluates the configured non-idempotent, execute and cacheable region rules from the core configuration, then returns the attribute bits together with a fetch-execute fault flag.
- Two register stages with elastic valid/ready handshakes keep the 16-rule, 65-bit range compares off the critical path.

Parameters:
- CVA6Cfg, cva6_cfg_empty, core configuration struct; supplies the rule counts, rule bases and rule lengths.
- TagWidth, 4, width of the opaque request tag carried through the pipe.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drops all in-flight lookups
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_addr_i  in  64  physical address
- req_tag_i  in  TagWidth  opaque tag
- req_fetch_i  in  1  request is an instruction fetch
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_addr_o  out  64  echoed address
- rsp_tag_o  out  TagWidth  echoed tag
- rsp_cacheable_o  out  1  address is inside a cacheable region
- rsp_nonidem_o  out  1  address is inside a non-idempotent region
- rsp_exec_o  out  1  address is inside an executable region
- rsp_fault_o  out  1  fetch to a non-executable address

Behaviour:
- Range rule: hit when base <= addr and {1'b0,addr} < 65'(base)+len. The 65-bit sum means a region ending exactly at 2^64 never wraps.
- Rule masking: rule index k contributes only if k < the corresponding Nr*Rules count. Rules at or beyond the count are forced to 0.
- Stage 1 (S1):
  - On accept, registers addr, tag and fetch.
  - Registers three 16-bit per-rule hit vectors (nonidem, exec, cached), computed combinationally from req_addr_i.
  - Sets s1_valid.
- Stage 2 (S2), drives the rsp_* outputs:
  - cacheable = |cached_hits.
  - nonidem = |nonidem_hits.
  - exec = (NrExecuteRegionRules == 0) ? 1 : |exec_hits.
  - fault = fetch & ~exec. Non-fetch requests never fault.
- Handshake (elastic, no bubbles at full throughput):
  - s2_ready = ~s2_valid | rsp_ready_i.
  - s1_ready = ~s1_valid | s2_ready.
  - req_ready_o = s1_ready & ~flush_i.
  - S1 moves to S2 when s1_valid & s2_ready.
  - S2 releases when rsp_valid_o & rsp_ready_i.
- Latency: exactly 2 cycles from the accept edge to rsp_valid_o when unstalled. Throughput is 1 per cycle.
- Stall: rsp_* are held stable while rsp_valid_o=1 and rsp_ready_i=0. The pipe buffers at most 2 entries; req_ready_o falls once both are full.
- Ordering: responses come out strictly in request order. No entry is lost or duplicated.
- Flush: at the flush_i edge, s1_valid and s2_valid clear to 0 and no request is accepted in that cycle. rsp_valid_o may be high in the flush cycle itself; a handshake that completes in that cycle is still a legal response.
- Simultaneous events: flush_i overrides both advance and accept. A response handshake and an S1-to-S2 advance in the same cycle both take effect.
- Reset (async, any time, including mid-transfer): all valid bits 0; all rsp_* data outputs 0; req_ready_o=1 the first cycle after reset is released.
- Elaboration: run check_cfg(CVA6Cfg) in a simulation-only initial block.

Test Plan:
Bench config for all tests unless a test states otherwise:
- NonIdem rule0: 0x0 / 0x8000_0000.
- Cached rule0: 0x8000_0000 / 0x4000_0000.
- Exec rule0: 0x1_0000 / 0x1_0000.
- Exec rule1: 0x8000_0000 / 0x4000_0000.

Scenarios:
- Basic lookup: req addr=0x8000_0000, fetch=1, tag=3, rsp_ready_i=1 -> rsp_valid_o 2 cycles later with tag=3, cacheable=1, nonidem=0, exec=1, fault=0. Then addr=0x1000_0000, fetch=0 -> nonidem=1, cacheable=0, exec=0, fault=0.
- Boundaries:
  - 0xBFFF_FFFF -> cacheable=1, exec=1.
  - 0xC000_0000, fetch=1 -> cacheable=0, exec=0, fault=1.
  - 0x7FFF_FFFF -> nonidem=1.
  - 0x2_0000 -> exec=0.
- Backpressure: 5 back-to-back reqs with tags 0..4 while rsp_ready_i=0 for 4 cycles -> req_ready_o low after 2 accepts; outputs stable while stalled; tags 0..4 emerge in order with no gaps once ready rises; single-cycle spacing resumes.
- Flush: 2 entries in flight, pulse flush_i with req_valid_i=1 -> no rsp_valid_o from the following cycle on; request in the flush cycle not accepted; next accepted request responds after 2 cycles.
- Config edges:
  - NrExecuteRegionRules=0 -> any address gives exec=1, fault=0.
  - Cached rule base 0xFFFF_FFFF_FFFF_F000, len 0x1000 -> addr 0xFFFF_FFFF_FFFF_FFFF gives cacheable=1; addr 0xFFFF_FFFF_FFFF_EFFF gives 0.
  - A rule populated at index >= NrCachedRegionRules is ignored.
- Reset mid-operation: assert rst_ni low asynchronously with 2 entries stalled -> rsp_valid_o=0 immediately and all rsp_* = 0; after release, req_ready_o=1 and a fresh lookup completes normally.
